// File: rtl/sop_pkg.sv
// sop_pkg: shared states, coefficient addresses and sum width for the sop sequencer
package sop_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  localparam logic [1:0] COEF11 = 2'd0;
  localparam logic [1:0] COEF12 = 2'd1;
  localparam logic [1:0] COEF21 = 2'd2;
  localparam logic [1:0] COEF22 = 2'd3;
  function automatic int sum_width(input int w);
    return 2 * w + 2;
  endfunction
endpackage

// File: rtl/sop_result_fifo.sv
// sop_result_fifo: first-word-fall-through result FIFO with registered head and occupancy count
module sop_result_fifo
  import sop_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic do_pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    do_pop = pop && cnt_q != '0;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = push_data;
    wr_d = push ? inc(wr_q) : wr_q;
    rd_d = do_pop ? inc(rd_q) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(do_pop);
    head_d = cnt_d == '0 ? head_q : mem_d[rd_d];
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      head_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      head_q <= head_d;
    end
  end
  assign out_valid = cnt_q != '0;
  assign out_data = head_q;
  assign count = cnt_q;
endmodule

// File: rtl/sop_sequencer.sv
// sop_sequencer: feeds samples into sum_of_products, tags them and collects results in a credit-protected FIFO
module sop_sequencer
  import sop_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int PIPE_LAT = 2,
  parameter int DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                flush,
  output logic                                busy,
  input  logic                                coef_wr,
  input  logic [1:0]                          coef_addr,
  input  logic [DATA_WIDTH-1:0]               coef_wdata,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH-1:0]               in_data,
  output logic [DATA_WIDTH-1:0]               sop_data,
  output logic [DATA_WIDTH-1:0]               sop_coef11,
  output logic [DATA_WIDTH-1:0]               sop_coef12,
  output logic [DATA_WIDTH-1:0]               sop_coef21,
  output logic [DATA_WIDTH-1:0]               sop_coef22,
  input  logic [sum_width(DATA_WIDTH)-1:0]    sop_sum,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [sum_width(DATA_WIDTH)-1:0]    out_data
);
  localparam int SW = sum_width(DATA_WIDTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(DEPTH + PIPE_LAT + 2);
  state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] coef_q [4];
  logic [DATA_WIDTH-1:0] coef_d [4];
  logic [DATA_WIDTH-1:0] sop_data_q, sop_data_d;
  logic [PIPE_LAT:0] tag_q, tag_d;
  logic [CW-1:0] fifo_count;
  logic [OW-1:0] occ;
  logic accept;
  always_comb begin
    occ = OW'(fifo_count) + OW'($countones(tag_q));
    in_ready = state_q == RUN && occ < OW'(DEPTH);
    accept = in_valid && in_ready;
    coef_d = coef_q;
    if (state_q == IDLE && coef_wr) coef_d[coef_addr] = coef_wdata;
    sop_data_d = accept ? in_data : '0;
    tag_d = {tag_q[PIPE_LAT-1:0], accept};
    state_d = state_q == IDLE ? (start ? RUN : IDLE) :
              state_q == RUN  ? (flush ? DRAIN : RUN) :
              (tag_q == '0 ? IDLE : DRAIN);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      coef_q <= '{default: '0};
      sop_data_q <= '0;
      tag_q <= '0;
    end else begin
      state_q <= state_d;
      coef_q <= coef_d;
      sop_data_q <= sop_data_d;
      tag_q <= tag_d;
    end
  end
  sop_result_fifo #(.WIDTH(SW), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (tag_q[PIPE_LAT]),
    .push_data(sop_sum),
    .pop      (out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .count    (fifo_count)
  );
  assign busy = state_q != IDLE;
  assign sop_data = sop_data_q;
  assign sop_coef11 = coef_q[COEF11];
  assign sop_coef12 = coef_q[COEF12];
  assign sop_coef21 = coef_q[COEF21];
  assign sop_coef22 = coef_q[COEF22];
endmodule

// File: tb/tb_sop_sequencer.sv
// tb_sop_sequencer: directed scoreboard bench for sop_sequencer with a delayed-sample datapath stub
module tb_sop_sequencer;
  localparam int W = 4;
  localparam int PL = 2;
  localparam int D = 4;
  localparam int SW = 2 * W + 2;
  logic clk = 0, rst = 0, start = 0, flush = 0, coef_wr = 0, in_valid = 0, out_ready = 0;
  logic [1:0] coef_addr = '0;
  logic [W-1:0] coef_wdata = '0, in_data = '0;
  logic busy, in_ready, out_valid;
  logic [W-1:0] sop_data, c11, c12, c21, c22;
  logic [SW-1:0] sop_sum, out_data;
  logic [W-1:0] pipe [PL];
  logic [SW-1:0] exp_q [$];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    pipe[0] <= sop_data;
    pipe[1] <= pipe[0];
  end
  assign sop_sum = {{(SW-W){1'b0}}, pipe[PL-1]};
  sop_sequencer #(.DATA_WIDTH(W), .PIPE_LAT(PL), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .busy(busy),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sop_data(sop_data), .sop_coef11(c11), .sop_coef12(c12), .sop_coef21(c21), .sop_coef22(c22),
    .sop_sum(sop_sum), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, want);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_empty(input string name);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_fifo_empty"}, out_valid, 0);
    tick();
  endtask
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got %0h, required no output", out_data);
      end else check("out_data", out_data, exp_q.pop_front());
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int nacc, nvalid;
    logic got;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sop_data", sop_data, 0);
    check("rst_coef11", c11, 0);
    tick();
    rst = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      coef_wr = 1;
      coef_addr = 2'(i);
      coef_wdata = W'(i + 1);
      tick();
    end
    coef_wr = 0;
    @(negedge clk);
    check("coef11", c11, 1);
    check("coef12", c12, 2);
    check("coef21", c21, 3);
    check("coef22", c22, 4);
    check("idle_in_ready", in_ready, 0);
    tick();
    start = 1;
    tick();
    start = 0;
    @(negedge clk);
    check("run_busy", busy, 1);
    tick();
    coef_wr = 1;
    coef_addr = 2;
    coef_wdata = 9;
    tick();
    coef_wr = 0;
    @(negedge clk);
    check("coef21_frozen", c21, 3);
    tick();
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_data = W'(5 + i);
      @(negedge clk);
      check("stream_ready", in_ready, 1);
      if (i == 3) check("stream_no_early_valid", out_valid, 0);
      exp_q.push_back(SW'(5 + i));
      tick();
    end
    in_valid = 0;
    @(negedge clk);
    check("stream_latency_valid", out_valid, 1);
    wait_empty("stream");
    out_ready = 0;
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1;
      in_data = W'(nacc + 1);
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(SW'(nacc + 1));
        nacc++;
      end
      tick();
    end
    check("bp_accepted", nacc, 4);
    tick();
    tick();
    in_data = 5;
    @(negedge clk);
    check("bp_ready_low", in_ready, 0);
    check("bp_full_valid", out_valid, 1);
    tick();
    out_ready = 1;
    tick();
    out_ready = 0;
    got = 0;
    for (int i = 0; i < 5 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(SW'(5));
        got = 1;
      end
      tick();
    end
    check("bp_refill", got, 1);
    in_valid = 0;
    out_ready = 1;
    wait_empty("bp");
    in_valid = 1;
    in_data = 3;
    @(negedge clk);
    check("bub_ready_a", in_ready, 1);
    exp_q.push_back(SW'(3));
    tick();
    in_valid = 0;
    @(negedge clk);
    check("bub_sop_3", sop_data, 3);
    tick();
    in_valid = 1;
    in_data = 4;
    @(negedge clk);
    check("bub_sop_0", sop_data, 0);
    check("bub_ready_b", in_ready, 1);
    exp_q.push_back(SW'(4));
    tick();
    in_valid = 0;
    @(negedge clk);
    check("bub_sop_4", sop_data, 4);
    wait_empty("bubble");
    in_valid = 1;
    in_data = 4'hA;
    flush = 1;
    @(negedge clk);
    check("flush_ready", in_ready, 1);
    exp_q.push_back(SW'(4'hA));
    tick();
    in_valid = 0;
    flush = 0;
    @(negedge clk);
    check("drain_busy", busy, 1);
    check("drain_in_ready", in_ready, 0);
    for (int i = 0; i < 8 && busy; i++) tick();
    check("flush_idle", busy, 0);
    wait_empty("flush");
    start = 1;
    out_ready = 0;
    tick();
    start = 0;
    in_valid = 1;
    in_data = 4'hB;
    tick();
    in_valid = 0;
    tick();
    in_valid = 1;
    in_data = 4'hC;
    tick();
    in_data = 4'hD;
    tick();
    in_valid = 0;
    @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    tick();
    rst = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_in_ready", in_ready, 0);
    check("mrst_busy", busy, 0);
    check("mrst_coef11", c11, 0);
    check("mrst_coef22", c22, 0);
    check("mrst_out_data", out_data, 0);
    tick();
    rst = 1;
    out_ready = 1;
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    check("mrst_no_stale", nvalid, 0);
    check("final_queue", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
